// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan timing generator (640x480@60 Hz by default).
// Divides the system clock down to the pixel rate and runs the horizontal
// and vertical scan counters. It issues active-area coordinates to the
// renderer and drives the VGA pins. The sync and blanking pipeline is delayed
// so that it lines up with the renderer's colour latency.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rgb         renderer colour {R,G,B}, valid RGB_LAT ticks after pix_x/pix_y
//   pix_x/y     active-area coordinates (0 outside the active span)
//   pix_tick    one-clk strobe per pixel tick
//   frame_tick  one-clk strobe when the scan enters vertical blanking
//   vga_hs/vs   active-low sync pins
//   vga_r/g/b   colour pins, forced to 0 while blanked
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RGB_LAT  = 1,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_cnt;
  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  logic       de;
  logic       hs_raw;
  logic       vs_raw;

  // Stage 0 takes the current scan position; stage RGB_LAT feeds the pins.
  logic [RGB_LAT:0] hs_sr;
  logic [RGB_LAT:0] vs_sr;
  logic [RGB_LAT:0] de_sr;

  // With CLK_DIV=1 DIV_LAST is 0, so tick is permanently high.
  assign tick  = (div_cnt == DIV_LAST);
  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_comb begin
    de     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Strobes are registered so they line up with the coordinates that the
  // same tick loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix_tick   <= tick;
      frame_tick <= tick && h_end && (v_cnt == V_ACT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (tick) begin
      pix_x <= (h_cnt < H_ACT) ? h_cnt : '0;
      pix_y <= (v_cnt < V_ACT) ? v_cnt[8:0] : '0;
    end
  end

  // A loop is used for the shift because a slice would be empty when
  // RGB_LAT is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
      de_sr <= '0;
    end else if (tick) begin
      hs_sr[0] <= hs_raw;
      vs_sr[0] <= vs_raw;
      de_sr[0] <= de;
      for (int unsigned i = 1; i < RGB_LAT + 1; i++) begin
        hs_sr[i] <= hs_sr[i - 1];
        vs_sr[i] <= vs_sr[i - 1];
        de_sr[i] <= de_sr[i - 1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (tick) begin
      vga_hs                <= hs_sr[RGB_LAT];
      vga_vs                <= vs_sr[RGB_LAT];
      {vga_r, vga_g, vga_b} <= de_sr[RGB_LAT] ? rgb : '0;
    end
  end

endmodule
